// File: rtl/serial_adder.sv
// rtl/serial_adder.sv - bit-serial WIDTH-bit adder, LSB first; SERIAL_ADDER_SUB_EN adds a sub port for a - b
module serial_adder #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
`ifdef SERIAL_ADDER_SUB_EN
    input  logic             sub,
`endif
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);

    localparam int CW = $clog2(WIDTH);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic [WIDTH-1:0] ra;
    logic [WIDTH-1:0] rb;
    logic             c;
    logic [CW-1:0]    cnt;
    logic             accept;
    logic             last;
    logic             s;
    logic [WIDTH-1:0] b_load;
    logic             c_load;

    // Subtraction is a + ~b + 1, so the serial slice itself never changes.
`ifdef SERIAL_ADDER_SUB_EN
    assign b_load = sub ? ~b : b;
    assign c_load = sub ? 1'b1 : cin;
`else
    assign b_load = b;
    assign c_load = cin;
`endif

    assign accept = start && ((state == IDLE) || (state == DONE));
    assign last   = (cnt == CW'(WIDTH - 1));
    assign s      = ra[0] ^ rb[0] ^ c;
    assign cout   = c;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = IDLE;
        case (state)
            IDLE:    state_nxt = start ? SHIFT : IDLE;
            SHIFT:   state_nxt = last ? DONE : SHIFT;
            DONE:    state_nxt = start ? SHIFT : IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        busy = 1'b0;
        done = 1'b0;
        case (state)
            SHIFT:   busy = 1'b1;
            DONE:    done = 1'b1;
            default: begin
                busy = 1'b0;
                done = 1'b0;
            end
        endcase
    end

    // Sum bits enter at the MSB and walk down, so after WIDTH shifts bit 0 sits at sum[0].
    always_ff @(posedge clk) begin
        if (rst) begin
            ra  <= '0;
            rb  <= '0;
            c   <= 1'b0;
            cnt <= '0;
            sum <= '0;
        end else if (accept) begin
            ra  <= a;
            rb  <= b_load;
            c   <= c_load;
            cnt <= '0;
        end else if (state == SHIFT) begin
            ra  <= ra >> 1;
            rb  <= rb >> 1;
            c   <= (ra[0] & rb[0]) | (c & (ra[0] ^ rb[0]));
            sum <= {s, sum[WIDTH-1:1]};
            cnt <= cnt + CW'(1);
        end
    end

endmodule

// File: tb/tb_serial_adder.sv
// tb/tb_serial_adder.sv - self-checking bench for serial_adder against an arithmetic reference model
module tb_serial_adder;

    localparam int WIDTH = 8;
`ifdef SERIAL_ADDER_SUB_EN
    localparam bit SUB_EN = 1'b1;
`else
    localparam bit SUB_EN = 1'b0;
`endif

    logic             clk   = 1'b0;
    logic             rst   = 1'b1;
    logic             start = 1'b0;
    logic             cin   = 1'b0;
    logic             sub   = 1'b0;
    logic [WIDTH-1:0] a     = '0;
    logic [WIDTH-1:0] b     = '0;
    logic             busy;
    logic             done;
    logic             cout;
    logic [WIDTH-1:0] sum;

    always #5 clk = ~clk;

    serial_adder #(.WIDTH(WIDTH)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .a     (a),
        .b     (b),
        .cin   (cin),
`ifdef SERIAL_ADDER_SUB_EN
        .sub   (sub),
`endif
        .busy  (busy),
        .done  (done),
        .sum   (sum),
        .cout  (cout)
    );

    int n_checks = 0;
    int n_pass   = 0;
    bit check_en = 1'b0;

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] want);
        n_checks++;
        if (got === want) n_pass++;
        else $display("FAIL %s: got 0x%0h, want 0x%0h", name, got, want);
    endtask

    // Reference: an accepted start schedules WIDTH busy cycles, then one done cycle carrying a+b+cin.
    int               left   = 0;
    bit               m_done = 1'b0;
    logic [WIDTH-1:0] m_sum  = '0;
    logic [WIDTH-1:0] p_sum  = '0;
    logic             m_cout = 1'b0;
    logic             p_cout = 1'b0;

    always @(posedge clk) begin
        int t;
        if (rst) begin
            left   = 0;
            m_done = 1'b0;
            m_sum  = '0;
            m_cout = 1'b0;
        end else if (left > 0) begin
            left--;
            m_done = (left == 0);
            if (left == 0) begin
                m_sum  = p_sum;
                m_cout = p_cout;
            end
        end else begin
            m_done = 1'b0;
            if (start) begin
                left = WIDTH;
                if (sub && SUB_EN) begin
                    p_sum  = a - b;
                    p_cout = (a >= b);
                end else begin
                    t      = int'(a) + int'(b) + int'(cin);
                    p_sum  = t[WIDTH-1:0];
                    p_cout = t[WIDTH];
                end
            end
        end
    end

    always @(negedge clk) begin
        if (check_en) begin
            chk("busy", busy, left > 0);
            chk("done", done, m_done);
            if (left == 0) begin
                chk("sum", sum, m_sum);
                chk("cout", cout, m_cout);
            end
        end
    end

    task automatic launch(input logic [WIDTH-1:0] ta, input logic [WIDTH-1:0] tb_, input logic tc,
                          input logic ts, output int lat, output int busy_n);
        a = ta; b = tb_; cin = tc; sub = ts; start = 1'b1;
        @(negedge clk);
        start  = 1'b0;
        lat    = 1;
        busy_n = 0;
        while (done !== 1'b1 && lat < 4 * WIDTH) begin
            if (busy === 1'b1) busy_n++;
            @(negedge clk);
            lat++;
        end
    endtask

    task automatic op(input logic [WIDTH-1:0] ta, input logic [WIDTH-1:0] tb_, input logic tc,
                      input logic ts, input logic [WIDTH-1:0] esum, input logic ecout);
        int lat, bn;
        @(negedge clk);
        launch(ta, tb_, tc, ts, lat, bn);
        chk("latency", lat, WIDTH + 1);
        chk("busy_cycles", bn, WIDTH);
        chk("sum_lit", sum, esum);
        chk("cout_lit", cout, ecout);
    endtask

    task automatic count_done(input int cycles, output int nd);
        nd = 0;
        repeat (cycles) begin
            @(negedge clk);
            if (done === 1'b1) nd++;
        end
    endtask

    initial begin
        int n, nd, lat, bn;
        rst = 1'b1;
        repeat (2) @(negedge clk);
        chk("reset_busy", busy, 1'b0);
        chk("reset_done", done, 1'b0);
        chk("reset_sum", sum, 8'h00);
        chk("reset_cout", cout, 1'b0);
        rst = 1'b0;
        check_en = 1'b1;

        op(8'h35, 8'h4A, 1'b0, 1'b0, 8'h7F, 1'b0);
        op(8'hFF, 8'h01, 1'b0, 1'b0, 8'h00, 1'b1);
        op(8'hFF, 8'hFF, 1'b1, 1'b0, 8'hFF, 1'b1);

        // start re-pulsed while busy must be ignored
        @(negedge clk);
        a = 8'h01; b = 8'h02; cin = 1'b0; sub = 1'b0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (2) @(negedge clk);
        a = 8'h11; b = 8'h22; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        n = 0;
        while (done !== 1'b1 && n < 4 * WIDTH) begin
            @(negedge clk);
            n++;
        end
        chk("repulse_done_seen", done, 1'b1);
        chk("repulse_sum", sum, 8'h03);
        count_done(20, nd);
        chk("repulse_extra_done", nd, 0);

        // reset during the 4th shift cycle discards the operation
        @(negedge clk);
        a = 8'hAA; b = 8'h55; cin = 1'b0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("midrst_busy", busy, 1'b0);
        chk("midrst_done", done, 1'b0);
        chk("midrst_sum", sum, 8'h00);
        chk("midrst_cout", cout, 1'b0);
        count_done(20, nd);
        chk("midrst_no_done", nd, 0);
        op(8'h12, 8'h34, 1'b0, 1'b0, 8'h46, 1'b0);

        // back-to-back: start held in the DONE cycle
        op(8'h01, 8'h01, 1'b0, 1'b0, 8'h02, 1'b0);
        launch(8'h10, 8'h20, 1'b0, 1'b0, lat, bn);
        chk("b2b_latency", lat, WIDTH + 1);
        chk("b2b_sum", sum, 8'h30);
        chk("b2b_cout", cout, 1'b0);

`ifdef SERIAL_ADDER_SUB_EN
        op(8'h10, 8'h01, 1'b0, 1'b1, 8'h0F, 1'b1);
        op(8'h01, 8'h02, 1'b0, 1'b1, 8'hFF, 1'b0);
        op(8'h05, 8'h05, 1'b1, 1'b1, 8'h00, 1'b1);
`endif

        repeat (3000) begin
            @(negedge clk);
            rst   = ($urandom_range(0, 199) == 0);
            start = ($urandom_range(0, 2) == 0);
            a     = WIDTH'($urandom);
            b     = WIDTH'($urandom);
            cin   = 1'($urandom);
            sub   = 1'($urandom);
            if ($urandom_range(0, 7) == 0) a = '1;
            if ($urandom_range(0, 7) == 0) b = '1;
        end
        @(negedge clk);
        rst = 1'b0;
        start = 1'b0;
        repeat (2 * WIDTH) @(negedge clk);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
